// File: rtl/nn_ctrl_pkg.sv
// Shared types and default sizing for the neuron training sequencer.
package nn_ctrl_pkg;

  localparam int NUM_HIDDEN_D = 2;
  localparam int HID_LAT_D    = 2;
  localparam int OUT_LAT_D    = 2;
  localparam int BWD_LAT_D    = 3;
  localparam int EPOCH_W_D    = 8;
  localparam int LOSS_W_D     = 42;
  localparam int TMR_W        = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FWD_H,
    FWD_O,
    LOSS_CHK,
    BWD,
    UPD,
    DONE
  } nn_state_e;

  // A stage of latency lat ends when the timer reaches zero, so it is loaded with lat-1.
  function automatic logic [TMR_W-1:0] lat_load(input int lat);
    return TMR_W'(lat - 1);
  endfunction

endpackage

// File: rtl/nn_stage_timer.sv
// Loadable down-counter with a zero flag; one instance times every latency stage.
module nn_stage_timer
  import nn_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nn_train_ctrl.sv
// Training sequencer: init load, then per epoch FWD_H/FWD_O/LOSS_CHK/BWD/UPD until done.
// Build option NN_EARLY_STOP_EN enables early stop when loss_i < loss_thresh_i.
module nn_train_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_HIDDEN = NUM_HIDDEN_D,
  parameter int HID_LAT    = HID_LAT_D,
  parameter int OUT_LAT    = OUT_LAT_D,
  parameter int BWD_LAT    = BWD_LAT_D,
  parameter int EPOCH_W    = EPOCH_W_D,
  parameter int LOSS_W     = LOSS_W_D
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [EPOCH_W-1:0]    epochs_i,
  input  logic [LOSS_W-1:0]     loss_i,
  input  logic [LOSS_W-1:0]     loss_thresh_i,
  output logic [NUM_HIDDEN-1:0] hn_en_o,
  output logic                  on_en_o,
  output logic                  bp_en_o,
  output logic                  wsel_init_o,
  output logic                  wupd_o,
  output logic [EPOCH_W-1:0]    epoch_o,
  output logic [LOSS_W-1:0]     loss_q_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  converged_o,
  output nn_state_e             state_o
);

  // Control semantics: start_i is a level sampled only in IDLE (no ready back);
  // abort_i is sampled every cycle and overrides any transition, forcing IDLE next.
  nn_state_e          state, nxt;
  logic [EPOCH_W-1:0] ep_tgt;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_zero;
  logic               last_ep;
  logic               early;

  assign last_ep = ((epoch_o + EPOCH_W'(1)) == ep_tgt);

`ifdef NN_EARLY_STOP_EN
  assign early = (loss_i < loss_thresh_i);
`else
  logic unused_thresh;
  assign early         = 1'b0;
  assign unused_thresh = ^loss_thresh_i;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (start_i) nxt = INIT;
      INIT:     nxt = (ep_tgt == '0) ? DONE : FWD_H;
      FWD_H:    if (tmr_zero) nxt = FWD_O;
      FWD_O:    if (tmr_zero) nxt = LOSS_CHK;
      LOSS_CHK: nxt = (last_ep || early) ? DONE : BWD;
      BWD:      if (tmr_zero) nxt = UPD;
      UPD:      nxt = FWD_H;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (abort_i) nxt = IDLE;
  end

  // Timer is (re)loaded on the edge that enters a timed stage.
  always_comb begin
    tmr_val  = '0;
    tmr_load = 1'b0;
    if (nxt != state) begin
      case (nxt)
        FWD_H: begin tmr_load = 1'b1; tmr_val = lat_load(HID_LAT); end
        FWD_O: begin tmr_load = 1'b1; tmr_val = lat_load(OUT_LAT); end
        BWD:   begin tmr_load = 1'b1; tmr_val = lat_load(BWD_LAT); end
        default: ;
      endcase
    end
  end

  nn_stage_timer #(.W(TMR_W)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Outputs decode the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      ep_tgt      <= '0;
      hn_en_o     <= '0;
      on_en_o     <= 1'b0;
      bp_en_o     <= 1'b0;
      wsel_init_o <= 1'b1;
      wupd_o      <= 1'b0;
      epoch_o     <= '0;
      loss_q_o    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      converged_o <= 1'b0;
    end else begin
      state   <= nxt;
      hn_en_o <= (nxt == FWD_H) ? {NUM_HIDDEN{1'b1}} : '0;
      on_en_o <= (nxt == FWD_O);
      bp_en_o <= (nxt == BWD);
      wupd_o  <= (nxt == INIT) || (nxt == UPD);
      busy_o  <= (nxt != IDLE);
      done_o  <= (nxt == DONE);
      if ((nxt == IDLE) || (nxt == INIT)) begin
        wsel_init_o <= 1'b1;
      end else if (nxt == UPD) begin
        wsel_init_o <= 1'b0;
      end
      if (!abort_i) begin
        case (state)
          IDLE: begin
            if (start_i) begin
              ep_tgt      <= epochs_i;
              epoch_o     <= '0;
              loss_q_o    <= '0;
              converged_o <= 1'b0;
            end
          end
          LOSS_CHK: begin
            loss_q_o <= loss_i;
            if (last_ep || early) epoch_o <= epoch_o + EPOCH_W'(1);
            if (early) converged_o <= 1'b1;
          end
          UPD:     epoch_o <= epoch_o + EPOCH_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: doc/nn_train_ctrl.md
Name: nn_train_ctrl

Overview:
- Training sequencer for the 2-hidden/1-output neuron datapath.
- Loads initial weights, then per epoch: forward pass through the hidden neurons, then the output neuron, then a loss check, then a backward pass, then a weight update.
- Drives the neuron enables and the init/backprop weight-select mux; counts epochs; reports done/converged to top level.
- Sits between the top-level tile wrapper and the hidden_neuron/output_neuron instances.

Parameters:
NUM_HIDDEN, 2, number of hidden neurons driven by hn_en_o
HID_LAT, 2, cycles hidden neurons need enabled to produce a valid output (>=1)
OUT_LAT, 2, cycles output neuron needs enabled for final_o/loss_o valid (>=1)
BWD_LAT, 3, cycles backprop logic needs enabled (>=1)
EPOCH_W, 8, epoch counter width
LOSS_W, 42, loss width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  start training run; sampled only in IDLE
abort_i  in  1  synchronous abort; returns to IDLE next cycle, no done_o
epochs_i  in  EPOCH_W  number of epochs; sampled with start_i
loss_i  in  LOSS_W  loss from output neuron
loss_thresh_i  in  LOSS_W  early-stop threshold (used only with feature)
hn_en_o  out  NUM_HIDDEN  hidden neuron enables
on_en_o  out  1  output neuron enable
bp_en_o  out  1  backprop enable
wsel_init_o  out  1  1 = weight mux selects init values, 0 = backprop values
wupd_o  out  1  one-cycle weight register load strobe
epoch_o  out  EPOCH_W  completed-epoch count
loss_q_o  out  LOSS_W  loss registered in LOSS_CHK
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse in DONE
converged_o  out  1  sticky until next start; set on early stop

Behaviour:
- Reset: state = IDLE; all outputs 0 except wsel_init_o = 1.
- IDLE: start_i = 1 -> INIT; latch epochs_i into ep_tgt; clear epoch_o, loss_q_o, converged_o. start_i in any other state is ignored.
- INIT (1 cycle): wsel_init_o = 1, wupd_o = 1. If ep_tgt == 0 -> DONE, else -> FWD_H.
- FWD_H: hn_en_o = all ones for HID_LAT cycles -> FWD_O.
- FWD_O: on_en_o = 1 for OUT_LAT cycles -> LOSS_CHK.
- LOSS_CHK (1 cycle): loss_q_o <= loss_i.
  - If epoch_o + 1 == ep_tgt: epoch_o++ -> DONE.
  - Otherwise -> BWD.
- BWD: bp_en_o = 1 for BWD_LAT cycles -> UPD.
- UPD (1 cycle): wsel_init_o = 0, wupd_o = 1, epoch_o++ -> FWD_H.
- DONE (1 cycle): done_o = 1 -> IDLE. epoch_o and loss_q_o hold until the next start.
- wsel_init_o returns to 1 only in IDLE/INIT.
- Full epoch = HID_LAT + OUT_LAT + BWD_LAT + 2 cycles (9 with defaults). Last epoch = HID_LAT + OUT_LAT + 1 cycles (5).
- Stage timer: a single down-counter loaded on stage entry. Enables are decoded from state only (registered outputs, no glitching).
- abort_i has priority over every transition. Next state = IDLE, enables drop, no wupd_o, epoch_o holds.
- Reset asserted mid-run: immediate return to the reset values.
- epoch_o does not wrap: ep_tgt <= 2^EPOCH_W - 1, so the compare terminates first.

Optional Feature:
- Macro NN_EARLY_STOP_EN.
- Defined: in LOSS_CHK, if loss_i < loss_thresh_i (unsigned), then converged_o = 1, epoch_o++, -> DONE, even when epochs remain. The epoch-target check still applies.
- Undefined: loss_thresh_i unused; converged_o tied 0; runs always complete ep_tgt epochs.

Decomposition:
- Package nn_ctrl_pkg: state enum (IDLE, INIT, FWD_H, FWD_O, LOSS_CHK, BWD, UPD, DONE), default widths, latency defaults.
- Sub-module nn_stage_timer: loadable down-counter with a zero flag, reused for all three latency stages.

Test Plan:
- Reset then idle: all outputs 0, wsel_init_o = 1, busy_o = 0; start_i held low for 20 cycles -> no change.
- epochs_i = 1, start at cycle t:
  - INIT t+1 with wupd_o pulse.
  - hn_en_o = 11 at t+2..t+3; on_en_o at t+4..t+5; LOSS_CHK t+6.
  - done_o at t+7; epoch_o = 1; bp_en_o never high.
- epochs_i = 3, start at t:
  - wupd_o pulses at t+1, t+10, t+19.
  - bp_en_o at t+7..t+9 and t+16..t+18.
  - done_o at t+25; epoch_o = 3.
- epochs_i = 0 -> INIT at t+1, done_o at t+2, epoch_o = 0, no neuron enables.
- abort_i at t+8 during BWD of a 3-epoch run -> IDLE at t+9; no done_o, no further wupd_o, epoch_o = 0. A new start then works normally.
- NN_EARLY_STOP_EN, epochs_i = 5, loss_thresh_i = 100:
  - loss_i = 200 in epoch 0, 50 in epoch 1.
  - done_o at t+16; converged_o = 1; epoch_o = 2; loss_q_o = 50.
